// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/handshake inputs plus every datapath strobe.
interface control_unit_if #(
  parameter int N_REGS = 16,
  parameter int OP_W   = 5
);
  logic [31:0]       ir;
  logic              mem_ready;
  logic              stop;
  logic [N_REGS-1:0] gpr_in;
  logic [N_REGS-1:0] gpr_out;
  logic              pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out;
  logic              read, ir_in, y_in, z_in, z_low_out;
  logic [OP_W-1:0]   alu_op;
  logic              run;
  logic              illegal;

  // Sequencer side
  modport master (
    input  ir, mem_ready, stop,
    output gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
           read, ir_in, y_in, z_in, z_low_out, alu_op, run, illegal
  );

  // Datapath side
  modport slave (
    output ir, mem_ready, stop,
    input  gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
           read, ir_in, y_in, z_in, z_low_out, alu_op, run, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore T-state sequencer driving the datapath strobes.
// Outputs decode from registered state only (plus IR fields in T3..T5),
// so an asynchronous reset drops every strobe immediately.
module control_unit #(
  parameter int N_REGS = 16,
  parameter int OP_W   = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALTED} state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  state_t          state, state_nxt;
  logic            t1_wait;    // already spent at least one cycle in T1
  logic            illegal_q;
  logic [OP_W-1:0] opcode;
  logic [3:0]      ra, rb, rc;
  logic            is_rr, is_un, is_halt, legal;

  assign opcode = bus.ir[31 -: OP_W];
  assign ra     = bus.ir[26:23];
  assign rb     = bus.ir[22:19];
  assign rc     = bus.ir[18:15];

  // add..or occupy a contiguous opcode range
  assign is_rr   = (opcode >= OP_ADD) && (opcode <= OP_OR);
  assign is_un   = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_halt = (opcode == OP_HALT);
  assign legal   = is_rr || is_un || is_halt || (opcode == OP_NOP);

  // Rn maps to bit (N_REGS-1-n)
  function automatic logic [N_REGS-1:0] reg_sel(input logic [3:0] n);
    reg_sel = {1'b1, {(N_REGS-1){1'b0}}} >> n;
  endfunction

  // State register, T1 wait tracking and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      t1_wait   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      t1_wait <= (state == T1) && !bus.mem_ready;
      if ((state == T3) && !legal) illegal_q <= 1'b1;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = T0;
      T0:     state_nxt = T1;
      T1:     state_nxt = bus.mem_ready ? T2 : T1;
      T2:     state_nxt = T3;
      T3: begin
        if (is_rr || is_un) state_nxt = T4;
        else if (is_halt)   state_nxt = HALTED;
        else                state_nxt = bus.stop ? HALTED : T0;  // nop / unsupported
      end
      T4:     state_nxt = T5;
      T5:     state_nxt = bus.stop ? HALTED : T0;
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore strobe decode
  always_comb begin
    bus.gpr_in    = '0;
    bus.gpr_out   = '0;
    bus.pc_out    = 1'b0;
    bus.pc_in     = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.mar_in    = 1'b0;
    bus.mdr_in    = 1'b0;
    bus.mdr_out   = 1'b0;
    bus.read      = 1'b0;
    bus.ir_in     = 1'b0;
    bus.y_in      = 1'b0;
    bus.z_in      = 1'b0;
    bus.z_low_out = 1'b0;
    bus.alu_op    = '0;
    bus.run       = (state != IDLE) && (state != HALTED);
    bus.illegal   = illegal_q;
    case (state)
      T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
      end
      T1: begin
        bus.z_low_out = 1'b1;
        bus.pc_in     = !t1_wait;   // load PC only once per fetch
        bus.read      = 1'b1;
        bus.mdr_in    = 1'b1;
      end
      T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      T3: begin
        if (is_rr) begin
          bus.gpr_out = reg_sel(rb);
          bus.y_in    = 1'b1;
        end
      end
      T4: begin
        if (is_rr || is_un) begin
          bus.gpr_out = is_rr ? reg_sel(rc) : reg_sel(rb);
          bus.alu_op  = opcode;
          bus.z_in    = 1'b1;
        end
      end
      T5: begin
        bus.z_low_out = 1'b1;
        bus.gpr_in    = reg_sel(ra);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  control_unit_if #(.N_REGS(16), .OP_W(5)) b ();

  control_unit #(.N_REGS(16), .OP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.master)
  );

  always #5 clk = ~clk;

  // strobe field: {pc_out,pc_in,inc_pc,mar_in,mdr_in,mdr_out,read,ir_in,y_in,z_in,z_low_out}
  localparam logic [10:0] S_NONE = 11'b00000000000;
  localparam logic [10:0] S_T0   = 11'b10110000010;
  localparam logic [10:0] S_T1   = 11'b01001010001;
  localparam logic [10:0] S_T1W  = 11'b00001010001;
  localparam logic [10:0] S_T2   = 11'b00000101000;
  localparam logic [10:0] S_Y    = 11'b00000000100;
  localparam logic [10:0] S_Z    = 11'b00000000010;
  localparam logic [10:0] S_ZL   = 11'b00000000001;

  typedef struct {
    string       nm;
    logic [49:0] v;
  } exp_t;

  exp_t exp_q[$];
  logic [49:0] act;

  assign act = {b.gpr_in, b.gpr_out, b.pc_out, b.pc_in, b.inc_pc, b.mar_in,
                b.mdr_in, b.mdr_out, b.read, b.ir_in, b.y_in, b.z_in,
                b.z_low_out, b.alu_op, b.run, b.illegal};

  function automatic logic [49:0] ev(input logic [15:0] gi, input logic [15:0] go,
                                     input logic [10:0] st, input logic [4:0] alu,
                                     input logic run, input logic ill);
    return {gi, go, st, alu, run, ill};
  endfunction

  // Monitor: one expected vector per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.nm, act, e.v);
      end
    end
  end

  task automatic cyc(input string nm, input logic [49:0] e, input logic mr,
                     input logic st, input logic [31:0] irv);
    exp_t x;
    @(posedge clk);
    #1;
    b.mem_ready = mr;
    b.stop      = st;
    b.ir        = irv;
    x.nm = nm;
    x.v  = e;
    exp_q.push_back(x);
  endtask

  task automatic rst_assert(input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    b.stop = 1'b0;
    x.nm = nm;
    x.v  = '0;
    exp_q.push_back(x);
  endtask

  task automatic rst_release(input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    x.nm = nm;
    x.v  = '0;   // still IDLE this cycle
    exp_q.push_back(x);
  endtask

  // Full ALU instruction; g3/g4/g5 are the hand-decoded one-hot register selects
  task automatic alu_instr(input string nm, input logic [31:0] irv,
                           input logic [15:0] g3, input logic y3,
                           input logic [15:0] g4, input logic [4:0] alu,
                           input logic [15:0] g5, input int waits,
                           input logic stop5, input logic noise,
                           input logic ill, input logic abort4);
    cyc({nm, ".t0"}, ev(16'h0, 16'h0, S_T0, 5'd0, 1'b1, ill), 1'b1, noise, irv);
    cyc({nm, ".t1"}, ev(16'h0, 16'h0, S_T1, 5'd0, 1'b1, ill), waits == 0, noise, irv);
    for (int i = 1; i <= waits; i++)
      cyc({nm, ".t1w"}, ev(16'h0, 16'h0, S_T1W, 5'd0, 1'b1, ill), i == waits, noise, irv);
    cyc({nm, ".t2"}, ev(16'h0, 16'h0, S_T2, 5'd0, 1'b1, ill), 1'b1, noise, irv);
    cyc({nm, ".t3"}, ev(16'h0, g3, y3 ? S_Y : S_NONE, 5'd0, 1'b1, ill), 1'b1, noise, irv);
    if (abort4) begin
      rst_assert({nm, ".t4rst"});
      return;
    end
    cyc({nm, ".t4"}, ev(16'h0, g4, S_Z, alu, 1'b1, ill), 1'b1, noise, irv);
    cyc({nm, ".t5"}, ev(g5, 16'h0, S_ZL, 5'd0, 1'b1, ill), 1'b1, stop5, irv);
  endtask

  // nop / halt / unsupported: fetch plus an empty T3
  task automatic nop_instr(input string nm, input logic [31:0] irv,
                           input logic stop3, input logic ill);
    cyc({nm, ".t0"}, ev(16'h0, 16'h0, S_T0, 5'd0, 1'b1, ill), 1'b1, 1'b0, irv);
    cyc({nm, ".t1"}, ev(16'h0, 16'h0, S_T1, 5'd0, 1'b1, ill), 1'b1, 1'b0, irv);
    cyc({nm, ".t2"}, ev(16'h0, 16'h0, S_T2, 5'd0, 1'b1, ill), 1'b1, 1'b0, irv);
    cyc({nm, ".t3"}, ev(16'h0, 16'h0, S_NONE, 5'd0, 1'b1, ill), 1'b1, stop3, irv);
  endtask

  task automatic halted(input string nm, input int n, input logic ill);
    for (int i = 0; i < n; i++)
      cyc(nm, ev(16'h0, 16'h0, S_NONE, 5'd0, 1'b0, ill), 1'b1, (i % 3) == 1, 32'h4A920000);
  endtask

  initial begin
    rst_n       = 1'b0;
    b.ir        = 32'h4A920000;
    b.mem_ready = 1'b1;
    b.stop      = 1'b0;

    rst_assert("reset");
    rst_release("idle");
    // and R5,R2,R4
    alu_instr("and", 32'h4A920000, 16'h2000, 1'b1, 16'h0800, 5'b01001, 16'h0400,
              0, 1'b0, 1'b0, 1'b0, 1'b0);
    // or R1,R7,R15 with three memory wait cycles
    alu_instr("or_wait", 32'h50BF8000, 16'h0100, 1'b1, 16'h0001, 5'b01010, 16'h4000,
              3, 1'b0, 1'b0, 1'b0, 1'b0);
    // neg R0,R0
    alu_instr("neg", 32'h80000000, 16'h0000, 1'b0, 16'h8000, 5'b10000, 16'h8000,
              0, 1'b0, 1'b0, 1'b0, 1'b0);
    // unsupported opcode 00000, flag rises after T3
    nop_instr("illop", 32'h00000000, 1'b0, 1'b0);
    nop_instr("nop", 32'hC8000000, 1'b0, 1'b1);
    // add R3,R3,R3: stop pulses outside T5 ignored, stop at T5 halts
    alu_instr("add_stop", 32'h19998000, 16'h1000, 1'b1, 16'h1000, 5'b00011, 16'h1000,
              0, 1'b1, 1'b1, 1'b1, 1'b0);
    halted("halted_stop", 3, 1'b1);

    rst_assert("reset2");
    rst_release("idle2");
    nop_instr("halt", 32'hD0000000, 1'b0, 1'b0);
    halted("halted_op", 20, 1'b0);

    rst_assert("reset3");
    rst_release("idle3");
    // not R9,R6 with one wait cycle
    alu_instr("not", 32'h8CB00000, 16'h0000, 1'b0, 16'h0200, 5'b10001, 16'h0040,
              1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop_instr("nop_stop", 32'hC8000000, 1'b1, 1'b0);
    halted("halted_nop", 2, 1'b0);

    rst_assert("reset4");
    rst_release("idle4");
    alu_instr("abort", 32'h4A920000, 16'h2000, 1'b1, 16'h0800, 5'b01001, 16'h0400,
              0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_release("idle5");
    alu_instr("and2", 32'h4A920000, 16'h2000, 1'b1, 16'h0800, 5'b01001, 16'h0400,
              0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
